// File: rtl/ifetch_dual.sv
// Dual-port instruction fetch: issues pc/pc+4 pairs to the ROM and queues the responses in order.
// Optional performance counters are compiled in when IFETCH_PERF_EN is defined.
module ifetch_dual #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] NOP      = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] addrA,
    output logic [31:0] addrB,
    input  logic [31:0] doutA,
    input  logic [31:0] doutB,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_flushed
`endif
);

    localparam int AW = $clog2(QDEPTH);

    logic [31:0]   pc;
    logic [31:0]   pc_p1;
    logic          vld_p1;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] tail_nx;
    logic [AW:0]   count;
    logic [AW+2:0] demand;
    logic          issue;
    logic          push;
    logic          pop;

    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];

    // Issue stage (p0): the pending pair is reserved before the pop is credited
    assign demand  = {2'b00, count} + {{(AW+1){1'b0}}, vld_p1, 1'b0} + (AW+3)'(2);
    assign issue   = !reset && !redirect_valid && (demand <= (AW+3)'(QDEPTH));
    assign addrA   = pc;
    assign addrB   = pc + 32'd4;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = vld_p1 && !redirect_valid && !reset;
    assign tail_nx   = tail + 1'b1;
    assign out_inst  = out_valid ? q_inst[head] : NOP;
    assign out_pc    = out_valid ? q_pc[head]   : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            vld_p1 <= 1'b0;
        end else begin
            if (issue)
                pc <= pc + 32'd8;
            vld_p1 <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            pc_p1 <= pc;
    end

    // Capture stage (p1): ROM data returns one cycle after issue, A ahead of B
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail]    <= doutA;
            q_pc[tail]      <= pc_p1;
            q_inst[tail_nx] <= doutB;
            q_pc[tail_nx]   <= pc_p1 + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(2);
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b11:   count <= count + 1'b1;
                2'b10:   count <= count + (AW+1)'(2);
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFFFFFF : s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued  <= '0;
            perf_flushed <= '0;
        end else begin
            if (issue)
                perf_issued <= sat_add(perf_issued, 32'd2);
            if (redirect_valid)
                perf_flushed <= sat_add(perf_flushed, 32'(count) + (vld_p1 ? 32'd2 : 32'd0));
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_dual.sv
// Directed bench for ifetch_dual with a registered dual-port ROM model.
module tb_ifetch_dual;

    logic        clk;
    logic        reset;
    logic [31:0] addrA, addrB;
    logic [31:0] doutA, doutB;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_issued, perf_flushed;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [256];

    ifetch_dual dut (
        .clk            (clk),
        .reset          (reset),
        .addrA          (addrA),
        .addrB          (addrB),
        .doutA          (doutA),
        .doutB          (doutB),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_flushed   (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        doutA <= rom[addrA[9:2]];
        doutB <= rom[addrB[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect n consecutive valid outputs starting at pc p
    task automatic expect_seq(input string tag, input logic [31:0] p, input int n);
        logic [31:0] cur;
        cur = p;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_pc"}, out_pc, cur);
            check({tag, "_inst"}, out_inst, rom[cur[9:2]]);
            cur = cur + 32'd4;
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 32'hA5000000 + i;
        rom[0]  = 32'hfe010113;
        rom[1]  = 32'h00112e23;
        rom[2]  = 32'h00812c23;
        rom[14] = 32'hfec42703;
        rom[15] = 32'h01800793;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;
        step();
        step();

        // Reset state
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst", out_inst, 32'h00000013);
        check("rst_pc", out_pc, 32'd0);
        check("rst_addrA", addrA, 32'd0);
        check("rst_addrB", addrB, 32'd4);

        // Fill latency and streaming with out_ready held
        reset = 1'b0;
        step();
        check("lat_valid1", {31'd0, out_valid}, 32'd0);
        step();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_inst", out_inst, 32'hfe010113);
        check("first_pc", out_pc, 32'd0);
        step();
        check("second_inst", out_inst, 32'h00112e23);
        check("second_pc", out_pc, 32'd4);
        step();
        check("third_inst", out_inst, 32'h00812c23);
        check("third_pc", out_pc, 32'd8);
        step();
        expect_seq("stream", 32'h0c, 12);

        // Backpressure from reset
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++)
            step();
        check("bp_addrA", addrA, 32'h10);
        check("bp_head_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head_pc", out_pc, 32'd0);
        step();
        check("bp_addrA_hold", addrA, 32'h10);
        out_ready = 1'b1;
        step();
        expect_seq("bp_drain", 32'h04, 5);

        // Redirect coinciding with a response push and a pop
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++)
            step();
        out_ready = 1'b1;
        step();
        step();
        step();
        check("pre_redir_pc", out_pc, 32'h0c);
        check("pre_redir_addrA", addrA, 32'h18);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h38;
        step();
        redirect_valid = 1'b0;
        check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        check("redir_addrA", addrA, 32'h38);
`ifdef IFETCH_PERF_EN
        check("perf_flushed", perf_flushed, 32'd3);
`endif
        step();
        check("redir_lat_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("redir_inst0", out_inst, 32'hfec42703);
        check("redir_pc0", out_pc, 32'h38);
        step();
        check("redir_inst1", out_inst, 32'h01800793);
        check("redir_pc1", out_pc, 32'h3c);
        step();
        expect_seq("redir_stream", 32'h40, 6);

        // Unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3a;
        step();
        redirect_valid = 1'b0;
        check("unal_addrA", addrA, 32'h38);
        check("unal_addrB", addrB, 32'h3c);
        check("unal_flush", {31'd0, out_valid}, 32'd0);
        step();
        step();
        check("unal_inst0", out_inst, 32'hfec42703);
        check("unal_pc0", out_pc, 32'h38);
        step();
        expect_seq("unal_stream", 32'h3c, 4);

        // Reset mid-stream
        reset = 1'b1;
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_inst", out_inst, 32'h00000013);
        check("mid_rst_addrA", addrA, 32'd0);
`ifdef IFETCH_PERF_EN
        check("mid_rst_issued", perf_issued, 32'd0);
        check("mid_rst_flushed", perf_flushed, 32'd0);
`endif
        reset = 1'b0;
        step();
        check("post_rst_lat", {31'd0, out_valid}, 32'd0);
        step();
        check("post_rst_inst", out_inst, 32'hfe010113);
        check("post_rst_pc", out_pc, 32'd0);
        step();
        expect_seq("post_rst_stream", 32'h04, 4);
`ifdef IFETCH_PERF_EN
        check("perf_issued_run", perf_issued, 32'd8);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
